// File: rtl/vector_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_mem_sequencer_if
//
// Purpose:
//   Bundles the request, memory-port and result signals of the vector memory
//   sequencer so that the sequencer and its environment connect with a single
//   port each.
//
// Signals (direction given from the sequencer side, modport master):
//   start               in   execute-stage result valid
//   memWrite, memRead   in   request type (both high means write)
//   isScalarInstruction in   1 = one lane, 0 = VECTOR_SIZE lanes
//   address             in   base address (DATA_WIDTH)
//   dataToWrite         in   store data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   memReadData         in   memory read data, one-cycle latency
//   laneMask            in   per-lane enable (only with VMEM_LANE_MASK_EN)
//   memAddr             out  memory address
//   memWriteEnable      out  memory write strobe
//   memWriteData        out  memory write data
//   readVector          out  assembled load result
//   stall               out  upstream hold while busy
//   done                out  one-cycle completion pulse
//
// Configuration macro: VMEM_LANE_MASK_EN adds laneMask.
// ---------------------------------------------------------------------------
interface vector_mem_sequencer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6
);

  logic                              start;
  logic                              memWrite;
  logic                              memRead;
  logic                              isScalarInstruction;
  logic [DATA_WIDTH-1:0]             address;
  logic [DATA_WIDTH*VECTOR_SIZE-1:0] dataToWrite;
  logic [DATA_WIDTH-1:0]             memReadData;
`ifdef VMEM_LANE_MASK_EN
  logic [VECTOR_SIZE-1:0]            laneMask;
`endif
  logic [DATA_WIDTH-1:0]             memAddr;
  logic                              memWriteEnable;
  logic [DATA_WIDTH-1:0]             memWriteData;
  logic [DATA_WIDTH*VECTOR_SIZE-1:0] readVector;
  logic                              stall;
  logic                              done;

  // Sequencer side
  modport master (
    input  start, memWrite, memRead, isScalarInstruction, address,
           dataToWrite, memReadData,
`ifdef VMEM_LANE_MASK_EN
           laneMask,
`endif
    output memAddr, memWriteEnable, memWriteData, readVector, stall, done
  );

  // Environment side (pipeline plus memory)
  modport slave (
    output start, memWrite, memRead, isScalarInstruction, address,
           dataToWrite, memReadData,
`ifdef VMEM_LANE_MASK_EN
           laneMask,
`endif
    input  memAddr, memWriteEnable, memWriteData, readVector, stall, done
  );

endinterface

// File: rtl/vector_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vector_mem_sequencer
//
// Purpose:
//   Serialises a scalar or vector load/store from the execute stage onto a
//   lane-wide memory port, one lane per cycle, and assembles load data back
//   into a full vector. The upstream pipeline is held with stall while busy
//   and a registered done pulse marks completion.
//
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    vector_mem_sequencer_if.master (request, memory port, result)
//
// Timing (accept cycle T, n lanes):
//   write: lane i issued on T+1+i, done on T+n+1
//   read : lane i issued on T+1+i, captured at end of T+2+i, done on T+n+2
//
// Configuration macro: VMEM_LANE_MASK_EN adds a per-lane mask latched at
//   accept; masked lanes keep their slot but neither write nor load data.
// ---------------------------------------------------------------------------
module vector_mem_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 6
) (
  input logic                   clk,
  input logic                   reset,
  vector_mem_sequencer_if.master bus
);

  localparam int CW = $clog2(VECTOR_SIZE + 1);
  localparam int VW = DATA_WIDTH * VECTOR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          laneIdx_q, laneIdx_d;
  logic [CW-1:0]          laneCount_q, laneCount_d;
  logic [DATA_WIDTH-1:0]  base_q, base_d;
  logic [VW-1:0]          data_q, data_d;
  logic [VECTOR_SIZE-1:0] mask_q, mask_d;
  logic                   pending_q, pending_d;
  logic [CW-1:0]          pendIdx_q, pendIdx_d;
  logic [VW-1:0]          readVector_q, readVector_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  memAddrC;
  logic                   memWriteEnableC;
  logic [DATA_WIDTH-1:0]  memWriteDataC;
  logic [DATA_WIDTH-1:0]  capVal;
  logic                   lastLane;

  // State register; reset overrides every update including an operation in
  // flight, so an aborted request never reaches its done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      laneIdx_q    <= '0;
      laneCount_q  <= '0;
      base_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      pending_q    <= 1'b0;
      pendIdx_q    <= '0;
      readVector_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      laneIdx_q    <= laneIdx_d;
      laneCount_q  <= laneCount_d;
      base_q       <= base_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      pendIdx_q    <= pendIdx_d;
      readVector_q <= readVector_d;
      done_q       <= done_d;
    end
  end

  assign lastLane = (laneIdx_q == laneCount_q - CW'(1));

  // Next-state, memory port drive and read-data capture.
  always_comb begin
    state_d         = state_q;
    laneIdx_d       = laneIdx_q;
    laneCount_d     = laneCount_q;
    base_d          = base_q;
    data_d          = data_q;
    mask_d          = mask_q;
    pending_d       = 1'b0;
    pendIdx_d       = pendIdx_q;
    readVector_d    = readVector_q;
    done_d          = 1'b0;
    memAddrC        = '0;
    memWriteEnableC = 1'b0;
    memWriteDataC   = '0;
    capVal          = '0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.memWrite || bus.memRead)) begin
          base_d      = bus.address;
          data_d      = bus.dataToWrite;
          laneCount_d = bus.isScalarInstruction ? CW'(1) : CW'(VECTOR_SIZE);
          laneIdx_d   = '0;
`ifdef VMEM_LANE_MASK_EN
          mask_d      = bus.laneMask;
`else
          mask_d      = '1;
`endif
          // A request flagged as both read and write is treated as a write.
          state_d     = bus.memWrite ? WRITE : READ;
        end
      end

      WRITE: begin
        memAddrC = base_q + DATA_WIDTH'(laneIdx_q);
        if (mask_q[laneIdx_q]) begin
          memWriteEnableC = 1'b1;
          memWriteDataC   = data_q[laneIdx_q*DATA_WIDTH +: DATA_WIDTH];
        end
        if (lastLane) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          laneIdx_d = laneIdx_q + CW'(1);
        end
      end

      READ: begin
        memAddrC  = base_q + DATA_WIDTH'(laneIdx_q);
        pending_d = 1'b1;
        pendIdx_d = laneIdx_q;
        if (lastLane) begin
          state_d = DRAIN;
        end else begin
          laneIdx_d = laneIdx_q + CW'(1);
        end
      end

      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The lane issued last cycle has its data on memReadData now. The first
    // capture of a load clears the whole vector so a scalar load leaves the
    // upper lanes at zero and the previous result stays visible until then.
    if (pending_q) begin
      if (mask_q[pendIdx_q]) begin
        capVal = bus.memReadData;
      end
      if (pendIdx_q == '0) begin
        readVector_d = '0;
      end
      readVector_d[pendIdx_q*DATA_WIDTH +: DATA_WIDTH] = capVal;
    end
  end

  assign bus.memAddr        = memAddrC;
  assign bus.memWriteEnable = memWriteEnableC;
  assign bus.memWriteData   = memWriteDataC;
  assign bus.readVector     = readVector_q;
  assign bus.stall          = (state_q != IDLE);
  assign bus.done           = done_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_mem_sequencer
//
// Directed bench for vector_mem_sequencer. The driver pushes the expected
// write beats and done pulses into a scoreboard queue as each request is
// issued; a monitor on the falling edge pops and compares every time the DUT
// strobes memWriteEnable or done, and checks stall against the busy window
// the driver predicts. A small byte memory with one-cycle read latency sits
// on the memory port.
// ---------------------------------------------------------------------------
module tb_vector_mem_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  vector_mem_sequencer_if #(.DATA_WIDTH(8), .VECTOR_SIZE(6)) bus();

  vector_mem_sequencer #(.DATA_WIDTH(8), .VECTOR_SIZE(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          isDone;
    int          cyc;
    logic [7:0]  addr;
    logic [7:0]  data;
    bit          chkRv;
    logic [47:0] rv;
  } ev_t;

  ev_t sb[$];

  int  compared   = 0;
  int  mismatched = 0;
  bit  monOn      = 1'b0;
  int  stallFrom  = 1;
  int  stallTo    = 0;

  // Byte memory model with preload port so only this block writes the array
  logic [7:0] mem [256];
  logic       preloadEn = 1'b0;
  logic [7:0] preloadAddr = '0;
  logic [7:0] preloadData = '0;

  always @(posedge clk) begin
    if (preloadEn) mem[preloadAddr] <= preloadData;
    else if (bus.memWriteEnable) mem[bus.memAddr] <= bus.memWriteData;
    bus.memReadData <= mem[bus.memAddr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation for each write beat or done pulse
  always @(negedge clk) begin
    if (monOn) begin
      ev_t e;
      checkOutput("stall", {63'd0, bus.stall},
                  {63'd0, (cyc >= stallFrom && cyc <= stallTo)});
      if (bus.memWriteEnable === 1'b1 || bus.done === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected event: we=%0b done=%0b addr=0x%0h at cycle %0d, expected none",
                   bus.memWriteEnable, bus.done, bus.memAddr, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("event kind", {63'd0, bus.done}, {63'd0, e.isDone});
          checkOutput("event cycle", 64'(cyc), 64'(e.cyc));
          if (!e.isDone) begin
            checkOutput("write addr", {56'd0, bus.memAddr}, {56'd0, e.addr});
            checkOutput("write data", {56'd0, bus.memWriteData}, {56'd0, e.data});
          end else if (e.chkRv) begin
            checkOutput("readVector", {16'd0, bus.readVector}, {16'd0, e.rv});
          end
        end
      end
    end
  end

  task automatic pushWrite(input int c, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.isDone = 1'b0; e.cyc = c; e.addr = a; e.data = d; e.chkRv = 1'b0; e.rv = '0;
    sb.push_back(e);
  endtask

  task automatic pushDone(input int c, input bit chk, input logic [47:0] rv);
    ev_t e;
    e.isDone = 1'b1; e.cyc = c; e.addr = '0; e.data = '0; e.chkRv = chk; e.rv = rv;
    sb.push_back(e);
  endtask

  // Drives a start for one cycle from the current cycle T; the caller is
  // positioned just after a rising edge. Returns one cycle later.
  task automatic applyStimulus(input logic wr, input logic rd, input logic sc,
                               input logic [7:0] base, input logic [47:0] data,
                               input logic [5:0] mask, input bit expAccept,
                               input logic [47:0] expRv, output int t);
    int n;
    logic [7:0] lane;
    bus.start = 1'b1;
    bus.memWrite = wr;
    bus.memRead = rd;
    bus.isScalarInstruction = sc;
    bus.address = base;
    bus.dataToWrite = data;
`ifdef VMEM_LANE_MASK_EN
    bus.laneMask = mask;
`endif
    t = cyc;
    n = sc ? 1 : 6;
    if (expAccept) begin
      stallFrom = t + 1;
      if (wr) begin
        for (int i = 0; i < n; i++) begin
          lane = data[i*8 +: 8];
          if (mask[i]) pushWrite(t + 1 + i, base + 8'(i), lane);
        end
        pushDone(t + n + 1, 1'b0, '0);
        stallTo = t + n;
      end else begin
        pushDone(t + n + 2, 1'b1, expRv);
        stallTo = t + n + 1;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.memWrite = 1'b0;
    bus.memRead = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    preloadEn = 1'b1; preloadAddr = a; preloadData = d;
    @(posedge clk); #1;
    preloadEn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t, t2, t3;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.memWrite = 1'b0;
    bus.memRead = 1'b0;
    bus.isScalarInstruction = 1'b0;
    bus.address = '0;
    bus.dataToWrite = '0;
`ifdef VMEM_LANE_MASK_EN
    bus.laneMask = '1;
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) preload(8'h20 + 8'(i), 8'hA0 + 8'(i));
    preload(8'hFF, 8'h5A);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    checkOutput("reset stall", {63'd0, bus.stall}, 64'd0);
    checkOutput("reset done", {63'd0, bus.done}, 64'd0);
    checkOutput("reset we", {63'd0, bus.memWriteEnable}, 64'd0);
    checkOutput("reset addr", {56'd0, bus.memAddr}, 64'd0);
    checkOutput("reset wdata", {56'd0, bus.memWriteData}, 64'd0);
    checkOutput("reset readVector", {16'd0, bus.readVector}, 64'd0);
    monOn = 1'b1;

    $display("[TB] vector write base 0x10");
    applyStimulus(1, 0, 0, 8'h10, 48'h060504030201, 6'h3F, 1, '0, t);
    waitUntil(t + 8);

    $display("[TB] vector read base 0x20");
    applyStimulus(0, 1, 0, 8'h20, '0, 6'h3F, 1, 48'hA5A4A3A2A1A0, t);
    waitUntil(t + 9);

    $display("[TB] scalar read base 0xFF");
    applyStimulus(0, 1, 1, 8'hFF, '0, 6'h3F, 1, 48'h00000000005A, t);
    waitUntil(t + 4);

    $display("[TB] vector write base 0xFE wraps");
    applyStimulus(1, 0, 0, 8'hFE, 48'h161514131211, 6'h3F, 1, '0, t);
    waitUntil(t + 8);

    $display("[TB] reset during vector write");
    applyStimulus(1, 0, 0, 8'h40, 48'h262524232221, 6'h3F, 0, '0, t);
    pushWrite(t + 1, 8'h40, 8'h21);
    pushWrite(t + 2, 8'h41, 8'h22);
    pushWrite(t + 3, 8'h42, 8'h23);
    stallFrom = t + 1;
    stallTo = t + 3;
    waitUntil(t + 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort stall", {63'd0, bus.stall}, 64'd0);
    checkOutput("abort we", {63'd0, bus.memWriteEnable}, 64'd0);
    checkOutput("abort addr", {56'd0, bus.memAddr}, 64'd0);
    checkOutput("abort readVector", {16'd0, bus.readVector}, 64'd0);
    waitUntil(t + 10);

    $display("[TB] read+write together performs a write");
    applyStimulus(1, 1, 1, 8'h30, 48'h000000000077, 6'h3F, 1, '0, t);
    waitUntil(t + 3);

    $display("[TB] start with no request type is ignored");
    applyStimulus(0, 0, 0, 8'h33, 48'hFFFFFFFFFFFF, 6'h3F, 0, '0, t);
    waitUntil(t + 5);
    checkOutput("idle after empty start", {63'd0, bus.stall}, 64'd0);

    $display("[TB] start during stall ignored, back-to-back in done cycle");
    applyStimulus(1, 0, 0, 8'h50, 48'hF6F5F4F3F2F1, 6'h3F, 1, '0, t);
    waitUntil(t + 2);
    applyStimulus(0, 1, 0, 8'h20, '0, 6'h3F, 0, '0, t2);
    waitUntil(t + 7);
    applyStimulus(0, 1, 0, 8'h50, '0, 6'h3F, 1, 48'hF6F5F4F3F2F1, t2);
    waitUntil(t2 + 8);
    applyStimulus(0, 1, 1, 8'h30, '0, 6'h3F, 1, 48'h000000000077, t3);
    waitUntil(t3 + 4);

`ifdef VMEM_LANE_MASK_EN
    $display("[TB] masked vector write and read");
    applyStimulus(1, 0, 0, 8'h60, 48'hC6C5C4C3C2C1, 6'b101010, 1, '0, t);
    waitUntil(t + 8);
    applyStimulus(0, 1, 0, 8'h50, '0, 6'b000111, 1, 48'h000000F3F2F1, t);
    waitUntil(t + 9);
`endif

    repeat (3) begin
      @(posedge clk); #1;
    end
    monOn = 1'b0;
    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: lane width in bits.
REQ-002 SHALL have parameter VECTOR_SIZE, default 6: lanes per vector.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: execute-stage result valid.
REQ-006 SHALL have ports memWrite and memRead, input, 1 each: request type.
REQ-007 SHALL have port isScalarInstruction, input, 1: 1 means one lane, 0 means VECTOR_SIZE lanes.
REQ-008 SHALL have port address, input, DATA_WIDTH: base address (execute output lane 0).
REQ-009 SHALL have port dataToWrite, input, DATA_WIDTH*VECTOR_SIZE: store data; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port memReadData, input, DATA_WIDTH: memory read data, one-cycle synchronous latency.
REQ-011 SHALL have ports memAddr (output, DATA_WIDTH), memWriteEnable (output, 1) and memWriteData (output, DATA_WIDTH): byte-wide memory port.
REQ-012 SHALL have ports readVector (output, DATA_WIDTH*VECTOR_SIZE), stall (output, 1) and done (output, 1): assembled load result, upstream hold, one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-014 In IDLE, start=1 with memWrite=1 or memRead=1 SHALL be accepted: latch address, dataToWrite, lane count (1 or VECTOR_SIZE) and type; go to WRITE if memWrite=1, else READ.
REQ-015 memWrite=1 and memRead=1 together SHALL be treated as a write.
REQ-016 start with memWrite=0 and memRead=0 SHALL be ignored: no state change, no done.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 stall SHALL be 1 exactly in WRITE, READ and DRAIN, and 0 in IDLE.
REQ-019 WRITE, lane i (i=0..n-1) SHALL be on cycle T+1+i after accept cycle T: memAddr=base+i, memWriteEnable=1, memWriteData=latched lane i.
REQ-020 After lane n-1, WRITE SHALL go to IDLE; done=1 in cycle T+n+1.
REQ-021 READ, lane i SHALL drive memAddr=base+i, memWriteEnable=0 on cycle T+1+i; memReadData on cycle T+2+i SHALL be captured into readVector lane i.
REQ-022 After issuing lane n-1, READ SHALL go to DRAIN for one cycle to capture the last lane, then to IDLE; done=1 in cycle T+n+2.
REQ-023 Addresses SHALL wrap modulo 2^DATA_WIDTH (base 0xFE, lane 2 gives 0x00).
REQ-024 Scalar reads SHALL zero readVector lanes 1..VECTOR_SIZE-1; vector reads SHALL update all lanes.
REQ-025 readVector SHALL hold its value until the next accepted read's first capture.
REQ-026 done SHALL be registered, high one cycle; a start in the done cycle (IDLE) SHALL be accepted.
REQ-027 Outside active write cycles, memWriteEnable=0 and memWriteData=0; memAddr=0 in IDLE.

Reset
REQ-028 reset=1 SHALL, at the next clk edge and with priority over all else, force IDLE, stall=0, done=0, memWriteEnable=0, memAddr=0, memWriteData=0 and readVector=0, including mid-operation; the aborted request SHALL produce no done.

Configuration
REQ-029 Macro VMEM_LANE_MASK_EN defined SHALL add input laneMask (VECTOR_SIZE bits), latched at accept; masked-off lanes keep their cycle slot but write with memWriteEnable=0 and load as zero; timing unchanged.
REQ-030 Without VMEM_LANE_MASK_EN, laneMask SHALL be absent and all lanes enabled.

Verification
REQ-031 Vector write, base 0x10, data lanes 0x01..0x06 -> writes 0x10..0x15 on T+1..T+6 with matching data; stall high T+1..T+6; done at T+7.
REQ-032 Vector read, base 0x20, memory[0x20+i]=0xA0+i -> readVector={0xA5..0xA0} (lane 5..0); done at T+8; no memWriteEnable.
REQ-033 Scalar read, base 0xFF, mem[0xFF]=0x5A -> lane0=0x5A, other lanes 0, done at T+3; vector write at base 0xFE -> addresses 0xFE,0xFF,0x00..0x03.
REQ-034 reset at T+3 of a vector write -> no writes from T+4, all outputs zero, no done; next start accepted normally.
REQ-035 memRead=memWrite=1 -> write performed; start with both 0 -> no activity; start during stall -> ignored; back-to-back start in done cycle -> accepted.
REQ-036 With VMEM_LANE_MASK_EN, mask 6'b101010 on vector write -> memWriteEnable only on lanes 1,3,5; done still at T+7.
